// File: rtl/md_sched_pkg.sv
// Shared MIPS HI/LO control constants: op encodings, latencies, FSM state codes.
// Also holds the small helpers used by the scheduler to classify ops and take magnitudes.
package md_sched_pkg;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [5:0] MUL_LAT = 6'd4;
  localparam logic [5:0] DIV_LAT = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_start(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_sched_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one step per enabled cycle.
// quo_next/rem_next expose the result of the current step so the caller can commit it on the final edge.
module md_divider
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  // quo_q starts as the dividend; its MSB is shifted into the remainder each step
  // while the new quotient bit enters at the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (diff[32]) begin
      rem_next = shifted[31:0];
      quo_next = {quo_q[30:0], 1'b0};
    end else begin
      rem_next = diff[31:0];
      quo_next = {quo_q[30:0], 1'b1};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = 32'd0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: fixed-latency MUL, iterative DIV, MTHI/MTLO,
// and the ID-stage stall that keeps MFHI/MFLO and back-to-back HI/LO ops ordered.
module md_sched
  import md_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_MdOp,
  input  logic [31:0] ex_busA,
  input  logic [31:0] ex_busB,
  input  logic        id_MdUse,
  output logic        MdStall,
  output logic        Busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        div_load;
  logic        div_step;
  logic        op_div_signed;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        quo_neg;
  logic        rem_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  assign op_div_signed = (ex_MdOp == OP_DIV);

  md_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag32(ex_busA, op_div_signed)),
    .divisor  (mag32(ex_busB, op_div_signed)),
    .quo_next (div_quo),
    .rem_next (div_rem)
  );

  // Low 64 bits of the product of sign/zero-extended operands is the correct result for both forms.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign quo_neg = sgn_q & (a_q[31] ^ b_q[31]);
  assign rem_neg = sgn_q & a_q[31];

  assign Busy    = (state_q != ST_IDLE);
  assign MdStall = id_MdUse & (Busy | is_start(ex_MdOp));
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_start(ex_MdOp)) begin
          a_d = ex_busA;
          b_d = ex_busB;
          if ((ex_MdOp == OP_MULT) || (ex_MdOp == OP_MULTU)) begin
            sgn_d   = (ex_MdOp == OP_MULT);
            count_d = MUL_LAT;
            state_d = ST_MUL;
          end else begin
            sgn_d    = op_div_signed;
            count_d  = DIV_LAT;
            div_load = 1'b1;
            state_d  = ST_DIV;
          end
        end else if (ex_MdOp == OP_MTHI) begin
          hi_d = ex_busA;
        end else if (ex_MdOp == OP_MTLO) begin
          lo_d = ex_busA;
        end
      end
      ST_MUL: begin
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        count_d  = count_q - 6'd1;
        div_step = 1'b1;
        if (count_q == 6'd1) begin
          // Divide-by-zero still takes the full latency but bypasses the sign fix-up.
          if (b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = a_q;
          end else begin
            lo_d = quo_neg ? (~div_quo + 32'd1) : div_quo;
            hi_d = rem_neg ? (~div_rem + 32'd1) : div_rem;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
